// File: rtl/frame_buf_arbiter_if.sv
// Bus bundle between frame_buf_arbiter and its video, control and RAM neighbours.
// slave is the arbiter's view; master is the surrounding system's view.
interface frame_buf_arbiter_if #(
  parameter int unsigned AW = 22,
  parameter int unsigned DW = 16
);
  logic          blanking;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_full;
  logic          wr_empty;
  logic [7:0]    ovf_cnt;
  logic          ram_oe;
  logic          ram_wr;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  modport slave (
    input  blanking, rd_req, rd_addr, wr_req, wr_addr, wr_data, ram_dout,
    output rd_data, rd_valid, wr_full, wr_empty, ovf_cnt,
           ram_oe, ram_wr, ram_addr, ram_din
  );

  modport master (
    output blanking, rd_req, rd_addr, wr_req, wr_addr, wr_data, ram_dout,
    input  rd_data, rd_valid, wr_full, wr_empty, ovf_cnt,
           ram_oe, ram_wr, ram_addr, ram_din
  );
endinterface

// File: rtl/frame_buf_arbiter.sv
// Shares the PSRAM port between video reads (absolute priority) and FIFO-buffered control writes.
// Define FRAME_BUF_ARB_WR_ACTIVE_EN to also drain writes during active video in read-free cycles.
module frame_buf_arbiter #(
  parameter int unsigned AW         = 22,
  parameter int unsigned DW         = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned RD_LAT     = 2
) (
  input logic              clk,
  input logic              rst,
  frame_buf_arbiter_if.slave bus
);
  localparam int unsigned IW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = IW + 1;

  // Encoding doubles as the RAM command bits: bit0 = oe, bit1 = wr.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10
  } state_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_entry_t;

  state_t            state, state_n;
  wr_entry_t         mem [FIFO_DEPTH];
  wr_entry_t         head_c;
  logic [PW-1:0]     wptr, rptr, wptr_n, rptr_n;
  logic              push_c, pop_c, rd_sel_c, wr_ok_c;
  logic [RD_LAT-1:0] vpipe;

`ifdef FRAME_BUF_ARB_WR_ACTIVE_EN
  assign wr_ok_c = 1'b1;
`else
  assign wr_ok_c = bus.blanking;
`endif

  assign head_c = mem[rptr[IW-1:0]];
  assign push_c = bus.wr_req && !bus.wr_full;
  assign pop_c  = (state_n == WR);
  assign wptr_n = wptr + PW'(push_c);
  assign rptr_n = rptr + PW'(pop_c);

  assign bus.ram_oe = state[0];
  assign bus.ram_wr = state[1];

  // Scheduler: reads win, writes fill otherwise-idle slots.
  always_comb begin
    state_n  = IDLE;
    rd_sel_c = bus.rd_req && !bus.blanking;
    if (rd_sel_c) begin
      state_n = RD;
    end else if (!bus.wr_empty && wr_ok_c) begin
      state_n = WR;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      wptr         <= '0;
      rptr         <= '0;
      bus.wr_full  <= 1'b0;
      bus.wr_empty <= 1'b1;
      bus.ovf_cnt  <= '0;
      bus.ram_addr <= '0;
      bus.ram_din  <= '0;
      vpipe        <= '0;
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
    end else begin
      state        <= state_n;
      wptr         <= wptr_n;
      rptr         <= rptr_n;
      bus.wr_empty <= (wptr_n == rptr_n);
      bus.wr_full  <= ((wptr_n ^ rptr_n) == {1'b1, {IW{1'b0}}});

      // Fullness is judged before any same-cycle pop.
      if (bus.wr_req && bus.wr_full && (bus.ovf_cnt != 8'hFF)) begin
        bus.ovf_cnt <= bus.ovf_cnt + 8'd1;
      end

      unique case (state_n)
        RD: bus.ram_addr <= bus.rd_addr;
        WR: begin
          bus.ram_addr <= head_c.addr;
          bus.ram_din  <= head_c.data;
        end
        default: ;
      endcase

      vpipe        <= RD_LAT'({vpipe, bus.ram_oe});
      bus.rd_valid <= vpipe[RD_LAT-1];
      if (vpipe[RD_LAT-1]) begin
        bus.rd_data <= bus.ram_dout;
      end
    end
  end

  // Storage carries no reset; the pointers define what is live.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wptr[IW-1:0]] <= '{addr: bus.wr_addr, data: bus.wr_data};
    end
  end
endmodule

// File: tb/tb_frame_buf_arbiter.sv
// Self-checking bench for frame_buf_arbiter: randomized stimulus against a queue-based model.
module tb_frame_buf_arbiter;
  localparam int unsigned AW = 22;
  localparam int unsigned DW = 16;
  localparam int unsigned FD = 8;
  localparam int          RD_LAT = 2;
  localparam int unsigned OW = 2 + AW + DW + 2 + 8 + 1 + DW;
`ifdef FRAME_BUF_ARB_WR_ACTIVE_EN
  localparam bit WR_ACTIVE = 1'b1;
`else
  localparam bit WR_ACTIVE = 1'b0;
`endif

  typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } ent_t;
  typedef struct packed { int unsigned due; logic [DW-1:0] data; } rsp_t;

  logic clk, rst;
  frame_buf_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  frame_buf_arbiter #(.AW(AW), .DW(DW), .FIFO_DEPTH(FD), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] ram_val(input logic [AW-1:0] a);
    return a[15:0] ^ {a[21:16], 10'h2A5} ^ 16'h5A3C;
  endfunction

  // RAM environment: data valid RD_LAT cycles after oe.
  logic [DW-1:0] dpipe [RD_LAT];
  always @(posedge clk) begin
    dpipe[0] <= bus.ram_oe ? ram_val(bus.ram_addr) : DW'(16'hDEAD);
    for (int i = 1; i < RD_LAT; i++) dpipe[i] <= dpipe[i-1];
  end
  assign bus.ram_dout = dpipe[RD_LAT-1];

  // Reference model state
  ent_t          mq[$];
  rsp_t          rdq[$];
  logic          e_oe, e_wr, e_full, e_empty, e_rv;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_din, e_rd;
  logic [7:0]    e_ovf;
  int unsigned   cyc = 0;
  int            total = 0;
  int            passed = 0;

  function automatic void model_reset();
    mq.delete(); rdq.delete();
    e_oe = 0; e_wr = 0; e_addr = '0; e_din = '0;
    e_full = 0; e_empty = 1; e_ovf = '0; e_rv = 0; e_rd = '0;
  endfunction

  // Predicts the outputs seen right after the next clock edge.
  function automatic void model_step(input logic bl, input logic rq, input logic [AW-1:0] ra,
                                     input logic wq, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    int unsigned n;
    bit          full_before;
    ent_t        e;
    rsp_t        r;
    n = cyc + 1;
    full_before = (mq.size() == FD);
    e_oe = 0; e_wr = 0;
    if (rq && !bl) begin
      e_oe = 1; e_addr = ra;
      r.due = n + RD_LAT + 1; r.data = ram_val(ra);
      rdq.push_back(r);
    end else if (mq.size() > 0 && (bl || WR_ACTIVE)) begin
      e = mq.pop_front();
      e_wr = 1; e_addr = e.addr; e_din = e.data;
    end
    if (wq) begin
      if (full_before) begin
        if (e_ovf != 8'hFF) e_ovf = e_ovf + 8'd1;
      end else begin
        e.addr = wa; e.data = wd;
        mq.push_back(e);
      end
    end
    e_full  = (mq.size() == FD);
    e_empty = (mq.size() == 0);
    e_rv = 0;
    if (rdq.size() > 0 && rdq[0].due == n) begin
      r = rdq.pop_front();
      e_rv = 1; e_rd = r.data;
    end
  endfunction

  function automatic logic [OW-1:0] observe();
    return {bus.ram_oe, bus.ram_wr, bus.ram_addr, bus.ram_din, bus.wr_full, bus.wr_empty,
            bus.ovf_cnt, bus.rd_valid, bus.rd_valid ? bus.rd_data : DW'(0)};
  endfunction

  function automatic logic [OW-1:0] expected();
    return {e_oe, e_wr, e_addr, e_din, e_full, e_empty, e_ovf, e_rv, e_rv ? e_rd : DW'(0)};
  endfunction

  task automatic drive_cycle(input logic bl, input logic rq, input logic [AW-1:0] ra,
                             input logic wq, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    bus.blanking = bl; bus.rd_req = rq; bus.rd_addr = ra;
    bus.wr_req = wq; bus.wr_addr = wa; bus.wr_data = wd;
    model_step(bl, rq, ra, wq, wa, wd);
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic test_reset();
    total++;
    if (observe() !== expected()) $display("FAIL reset_init got=%h exp=%h", observe(), expected());
    else passed++;
    #4 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b1, AW'($urandom), 1'b0, '0, '0);
      total++;
      if (observe() !== expected()) $display("FAIL reset_rd cyc=%0d got=%h exp=%h", cyc, observe(), expected());
      else passed++;
    end
    total++;
    if (bus.ram_oe !== 1'b1) $display("FAIL reset_midread_oe got=%b exp=1", bus.ram_oe);
    else passed++;
    #2 rst = 1'b1;
    model_reset();
    #1;
    total++;
    if (observe() !== expected()) $display("FAIL reset_async got=%h exp=%h", observe(), expected());
    else passed++;
    total++;
    if (bus.rd_data !== '0) $display("FAIL reset_rd_data got=%h exp=0", bus.rd_data);
    else passed++;
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b0, 1'b0, '0, 1'b0, '0, '0);
      total++;
      if (bus.rd_valid !== 1'b0 || observe() !== expected())
        $display("FAIL reset_no_valid cyc=%0d got=%h exp=%h", cyc, observe(), expected());
      else passed++;
    end
  endtask

  task automatic test_read_priority();
    int oe_cnt, rv_cnt;
    oe_cnt = 0; rv_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b0, '0, 1'b1, AW'($urandom), DW'($urandom));
      total++;
      if (observe() !== expected()) $display("FAIL rdpri_push cyc=%0d got=%h exp=%h", cyc, observe(), expected());
      else passed++;
    end
    for (int i = 0; i < 20; i++) begin
      drive_cycle(1'b0, i < 16, AW'(32'h10 + i), 1'b0, '0, '0);
      if (bus.ram_oe === 1'b1) oe_cnt++;
      if (bus.rd_valid === 1'b1) rv_cnt++;
      total++;
      if (observe() !== expected()) $display("FAIL rdpri_model cyc=%0d got=%h exp=%h", cyc, observe(), expected());
      else passed++;
      if (i < 16) begin
        total++;
        if (bus.ram_oe !== 1'b1 || bus.ram_wr !== 1'b0)
          $display("FAIL rdpri_cmd i=%0d got oe=%b wr=%b exp oe=1 wr=0", i, bus.ram_oe, bus.ram_wr);
        else passed++;
      end
    end
    total++;
    if (oe_cnt != 16 || rv_cnt != 16) $display("FAIL rdpri_counts got oe=%0d rv=%0d exp 16/16", oe_cnt, rv_cnt);
    else passed++;
  endtask

  task automatic test_blanking_drain();
    int wr_cnt;
    wr_cnt = 0;
    for (int i = 0; i < 10; i++) drive_cycle(1'b1, 1'b0, '0, 1'b0, '0, '0);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b0, 1'b1, AW'($urandom), 1'b1, AW'(32'h100 + i), DW'(32'hA000 + i));
      total++;
      if (observe() !== expected()) $display("FAIL drain_push cyc=%0d got=%h exp=%h", cyc, observe(), expected());
      else passed++;
    end
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b1, 1'b0, '0, 1'b0, '0, '0);
      total++;
      if (observe() !== expected()) $display("FAIL drain_model cyc=%0d got=%h exp=%h", cyc, observe(), expected());
      else passed++;
      if (bus.ram_wr === 1'b1) begin
        total++;
        if (bus.ram_addr !== AW'(32'h100 + wr_cnt) || bus.ram_din !== DW'(32'hA000 + wr_cnt))
          $display("FAIL drain_order n=%0d got=%h/%h exp=%h/%h", wr_cnt, bus.ram_addr, bus.ram_din,
                   AW'(32'h100 + wr_cnt), DW'(32'hA000 + wr_cnt));
        else passed++;
        wr_cnt++;
      end
    end
    total++;
    if (wr_cnt != 5 || bus.wr_empty !== 1'b1) $display("FAIL drain_count got=%0d empty=%b exp=5 empty=1", wr_cnt, bus.wr_empty);
    else passed++;
  endtask

  task automatic test_overflow();
    int wr_cnt;
    wr_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b0, 1'b1, AW'($urandom), 1'b1, AW'(32'h200 + i), DW'($urandom));
      total++;
      if (observe() !== expected()) $display("FAIL ovf_model cyc=%0d got=%h exp=%h", cyc, observe(), expected());
      else passed++;
      if (i == 7) begin
        total++;
        if (bus.wr_full !== 1'b1) $display("FAIL ovf_full got=%b exp=1", bus.wr_full);
        else passed++;
      end
    end
    total++;
    if (bus.ovf_cnt !== 8'd2) $display("FAIL ovf_cnt got=%0d exp=2", bus.ovf_cnt);
    else passed++;
    for (int i = 0; i < 12; i++) begin
      drive_cycle(1'b1, 1'b0, '0, 1'b0, '0, '0);
      total++;
      if (observe() !== expected()) $display("FAIL ovf_drain cyc=%0d got=%h exp=%h", cyc, observe(), expected());
      else passed++;
      if (bus.ram_wr === 1'b1) begin
        total++;
        if (bus.ram_addr !== AW'(32'h200 + wr_cnt)) $display("FAIL ovf_order got=%h exp=%h", bus.ram_addr, AW'(32'h200 + wr_cnt));
        else passed++;
        wr_cnt++;
      end
    end
    total++;
    if (wr_cnt != 8) $display("FAIL ovf_drain_count got=%0d exp=8", wr_cnt);
    else passed++;
  endtask

  task automatic test_ovf_saturate();
    for (int i = 0; i < 300; i++) begin
      drive_cycle(1'b0, 1'b1, AW'($urandom), 1'b1, AW'($urandom), DW'($urandom));
      total++;
      if (observe() !== expected()) $display("FAIL sat_model cyc=%0d got=%h exp=%h", cyc, observe(), expected());
      else passed++;
    end
    total++;
    if (bus.ovf_cnt !== 8'd255) $display("FAIL sat_cnt got=%0d exp=255", bus.ovf_cnt);
    else passed++;
    for (int i = 0; i < 12; i++) drive_cycle(1'b1, 1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b1, AW'($urandom), 1'b1, AW'($urandom), DW'($urandom));
    for (int i = 0; i < 12; i++) begin
      drive_cycle(1'b1, 1'b0, '0, 1'b1, AW'($urandom), DW'($urandom));
      total++;
      if (observe() !== expected()) $display("FAIL b2b_model cyc=%0d got=%h exp=%h", cyc, observe(), expected());
      else passed++;
      total++;
      if (bus.ram_wr !== 1'b1 || bus.wr_full !== 1'b0 || bus.wr_empty !== 1'b0)
        $display("FAIL b2b_flags i=%0d got wr=%b full=%b empty=%b exp 1/0/0", i, bus.ram_wr, bus.wr_full, bus.wr_empty);
      else passed++;
    end
    for (int i = 0; i < 8; i++) drive_cycle(1'b1, 1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic test_wr_active();
    int  wr_cnt;
    logic rq;
    wr_cnt = 0;
    for (int i = 0; i < 2; i++) drive_cycle(1'b0, 1'b1, AW'($urandom), 1'b1, AW'($urandom), DW'($urandom));
    for (int i = 0; i < 8; i++) begin
      rq = (i % 2 == 0);
      drive_cycle(1'b0, rq, AW'($urandom), 1'b0, '0, '0);
      if (bus.ram_wr === 1'b1) wr_cnt++;
      total++;
      if (observe() !== expected()) $display("FAIL wract_model cyc=%0d got=%h exp=%h", cyc, observe(), expected());
      else passed++;
      total++;
      if (bus.ram_wr === 1'b1 && (rq || !WR_ACTIVE)) $display("FAIL wract_slot i=%0d got wr=1 exp wr=0", i);
      else passed++;
    end
    total++;
    if (wr_cnt != (WR_ACTIVE ? 2 : 0)) $display("FAIL wract_count got=%0d exp=%0d", wr_cnt, WR_ACTIVE ? 2 : 0);
    else passed++;
    for (int i = 0; i < 6; i++) drive_cycle(1'b1, 1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive_cycle($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 6, AW'($urandom),
                  $urandom_range(0, 1) == 1, AW'($urandom), DW'($urandom));
      total++;
      if (observe() !== expected()) $display("FAIL random_model cyc=%0d got=%h exp=%h", cyc, observe(), expected());
      else passed++;
    end
  endtask

  initial begin
    bus.blanking = 1'b0; bus.rd_req = 1'b0; bus.rd_addr = '0;
    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    rst = 1'b1;
    model_reset();
    #3;
    test_reset();
    test_read_priority();
    test_blanking_drain();
    test_overflow();
    test_ovf_saturate();
    test_back_to_back();
    test_wr_active();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/frame_buf_arbiter.md
# frame_buf_arbiter

Single-clock arbiter that shares the PSRAM frame-buffer port between the video scan-out read path and the UART control write path. Reads from the video controller have absolute priority. Control writes are buffered in a small FIFO and drained only in cycles with no read, by default only during blanking. The block sits between `video_controller`/`Control` and `ram`, and replaces ad-hoc set/clear flag handshakes across the pixel-clock boundary.

## Interface
Parameters:
- `AW`, 22, RAM word-address width
- `DW`, 16, RAM data width
- `FIFO_DEPTH`, 8, write-FIFO entries; must be a power of two, at least 2
- `RD_LAT`, 2, cycles from `O_ram_oe` high to valid `I_ram_dout`; must be at least 1

Ports:
- `I_clk`  in  1  sole clock; all logic on its rising edge
- `I_rst`  in  1  asynchronous, active-high reset
- `I_blanking`  in  1  high outside active video
- `I_rd_req`  in  1  video read request, sampled every cycle
- `I_rd_addr`  in  AW  read address qualified by `I_rd_req`
- `O_rd_data`  out  DW  read data
- `O_rd_valid`  out  1  one-cycle pulse qualifying `O_rd_data`
- `I_wr_req`  in  1  write push strobe, one entry per high cycle
- `I_wr_addr`  in  AW  write address
- `I_wr_data`  in  DW  write data
- `O_wr_full`  out  1  FIFO holds `FIFO_DEPTH` entries
- `O_wr_empty`  out  1  FIFO holds 0 entries
- `O_ovf_cnt`  out  8  saturating count of dropped pushes
- `O_ram_oe`  out  1  read command to `ram`
- `O_ram_wr`  out  1  write command to `ram`
- `O_ram_addr`  out  AW  command address
- `O_ram_din`  out  DW  write data
- `I_ram_dout`  in  DW  read data from `ram`

## Operation
- Scheduler states: `IDLE`, `RD`, `WR`. The state equals the registered command presented on the RAM port this cycle. The next state is decided from the inputs sampled in the current cycle.
- `RD` is selected when `I_rd_req`=1 and `I_blanking`=0. It always wins.
- `WR` is selected when `RD` is not selected, the FIFO is non-empty, and `I_blanking`=1. This is widened under the configuration macro below.
- `IDLE` is selected otherwise.
- `RD`: `O_ram_oe`=1, `O_ram_addr`=captured `I_rd_addr`, `O_ram_wr`=0.
- `WR`: pops the FIFO head. Drives `O_ram_wr`=1, `O_ram_addr` and `O_ram_din` from the head entry, `O_ram_oe`=0.
- `IDLE`: `O_ram_oe`=`O_ram_wr`=0. Address and data hold their last values.
- `O_ram_oe` and `O_ram_wr` are never high in the same cycle.
- Back-to-back `RD` or `WR` cycles are allowed. There is no turnaround cycle.
- `I_rd_req` while `I_blanking`=1 is ignored: no command is issued and no `O_rd_valid` is produced.
- Read return path:
  - a valid shift register of length `RD_LAT`+1 tracks each issued read;
  - `O_rd_data` captures `I_ram_dout` `RD_LAT` cycles after `O_ram_oe`;
  - `O_rd_valid` pulses with the captured data;
  - responses return in issue order.
- FIFO push:
  - a push is accepted when `I_wr_req`=1 and the FIFO is not full;
  - fullness is evaluated before any same-cycle pop, so a push while full is dropped even if a pop occurs in that cycle;
  - each dropped push increments `O_ovf_cnt`, which saturates at 255.
- FIFO push and pop in the same cycle leave the count unchanged.
- Pointers are `log2(FIFO_DEPTH)`+1 bits wide and wrap modulo 2·`FIFO_DEPTH`.
  - Full: the MSBs differ and the remaining bits are equal.
  - Empty: the pointers are equal.
- Reset, asynchronous, any time including mid-read:
  - state returns to `IDLE`;
  - every output is 0: `O_ram_oe`, `O_ram_wr`, `O_ram_addr`, `O_ram_din`, `O_rd_data`, `O_rd_valid`, `O_wr_full`, `O_ovf_cnt`;
  - `O_wr_empty`=1;
  - the valid pipe clears, so in-flight reads never produce `O_rd_valid`;
  - FIFO contents are discarded.

## Timing
- All outputs are registered.
- Read latency: `I_rd_req` sampled at edge t gives `O_ram_oe` at t+1 and `O_rd_valid`/`O_rd_data` at t+1+`RD_LAT`+1. With the default `RD_LAT`=2, this is edge t+4.
- Write latency:
  - `I_wr_req` at edge t means the entry is visible at t+1;
  - the earliest `O_ram_wr` is at t+2, provided a write slot exists at t+1;
  - `O_wr_empty` falls at t+1.
- Flags: `O_wr_full` and `O_wr_empty` update the cycle after the push or pop that changes them.
- Throughput: one RAM command per cycle. A full FIFO drains in `FIFO_DEPTH` consecutive blanking cycles.

## Configuration
- Macro: `FRAME_BUF_ARB_WR_ACTIVE_EN`.
- Defined: `WR` is also permitted while `I_blanking`=0, in any cycle with `I_rd_req`=0. Reads still always win.
- Undefined (default): writes are issued only while `I_blanking`=1. Active video sees reads only.

## Test plan
- Reset priority: assert `I_rst` mid-read, with `O_ram_oe` high and 2 reads in flight.
  - All outputs go to 0 asynchronously and `O_wr_empty`=1.
  - After deassertion, no `O_rd_valid` appears within 8 cycles.
- Read priority, `I_blanking`=0, `I_rd_req` held 16 cycles at addresses 0x10..0x1F, with 3 writes queued:
  - `O_ram_oe` is high for 16 consecutive cycles and `O_ram_wr` stays 0;
  - `O_rd_valid` pulses 16 times, 3 cycles after each `O_ram_oe`, with addresses in order.
- Blanking drain: push 5 writes (addr 0x100+n, data 0xA000+n) during active video, then raise `I_blanking`.
  - Exactly 5 `O_ram_wr` pulses occur, in push order, with matching address/data.
  - `O_wr_empty` returns to 1.
- Overflow: push 10 writes with `I_blanking`=0, so no drain occurs.
  - `O_wr_full`=1 after the 8th push and `O_ovf_cnt`=2.
  - A later blanking drain writes only entries 0..7.
- Simultaneous push and pop: with the FIFO at count 4 and `I_blanking`=1, drive `I_wr_req` every cycle.
  - Count stays 4 and flags stay 0.
  - `O_ram_wr` is high every cycle.
- Macro defined: `I_blanking`=0, `I_rd_req` toggling 1/0, 2 writes queued.
  - Writes issue only in the `I_rd_req`=0 slots.
  - Without the macro, no write issues until `I_blanking`=1.
